spi_flash_master: RTL and testbench



---
 rtl/spi_flash_master_pkg.sv | 29 ++
 rtl/spi_shift_engine.sv | 127 ++++++++++++
 rtl/spi_flash_master.sv | 159 +++++++++++++++
 tb/tb_spi_flash_master.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_master_pkg.sv
// Shared opcodes, frame constants and FSM state encoding for the SPI flash bridge.
package spi_flash_master_pkg;

  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_PP   = 8'h02;
  localparam logic [7:0] OP_WREN = 8'h06;
  localparam logic [7:0] OP_WRDI = 8'h04;  // reserved, not issued

  localparam int unsigned FRAME_W  = 40;
  localparam logic [5:0]  LEN_CMD  = 6'd8;
  localparam logic [5:0]  LEN_XFER = 6'd40;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WREN = 3'd1,
    ST_GAP  = 3'd2,
    ST_XFER = 3'd3,
    ST_HOLD = 3'd4,
    ST_ACK  = 3'd5
  } state_e;

  // Build a full command frame: opcode, 24-bit address, data byte (MSB first).
  function automatic logic [FRAME_W-1:0] build_frame(input logic [7:0]  op,
                                                      input logic [23:0] adr,
                                                      input logic [7:0]  dat);
    return {op, adr, dat};
  endfunction

endpackage

// File: rtl/spi_shift_engine.sv
// SPI mode-0 bit engine: SCK divider, MSB-first shifting, MISO sampling,
// frame tail and minimum slave-select high time between frames.
module spi_shift_engine
  import spi_flash_master_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [5:0]         len_i,
  input  logic [FRAME_W-1:0] load_i,
  input  logic               miso_i,
  output logic               sck_o,
  output logic               ss_o,
  output logic               mosi_o,
  output logic               ready_o,
  output logic               tail_o,
  output logic               done_o,
  output logic [7:0]         rx_byte_o
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned GAP_W = $clog2(2 * CLK_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_MIN  = GAP_W'(2 * CLK_DIV);

  // mosi_q carries the frame MSB currently on the wire; shreg_q holds the rest.
  logic               active_q, active_d;
  logic               sck_q, sck_d;
  logic               ss_q, ss_d;
  logic               mosi_q, mosi_d;
  logic               done_q, done_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [5:0]         bit_q, bit_d;
  logic [FRAME_W-2:0] shreg_q, shreg_d;
  logic [7:0]         rx_q, rx_d;
  logic [GAP_W-1:0]   idle_q, idle_d;

  // Next-state logic: frame start, half-period ticks, rise/fall/tail handling.
  always_comb begin
    active_d = active_q;
    sck_d    = sck_q;
    ss_d     = ss_q;
    mosi_d   = mosi_q;
    done_d   = 1'b0;
    div_d    = div_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    rx_d     = rx_q;
    idle_d   = idle_q;
    if (start_i && !active_q) begin
      active_d = 1'b1;
      ss_d     = 1'b0;
      sck_d    = 1'b0;
      div_d    = DIV_LAST;
      bit_d    = len_i;
      mosi_d   = load_i[FRAME_W-1];
      shreg_d  = load_i[FRAME_W-2:0];
    end else if (active_q) begin
      if (div_q == {DIV_W{1'b0}}) begin
        div_d = DIV_LAST;
        if (sck_q) begin
          // falling edge: present the next bit, or park low after the last one
          sck_d   = 1'b0;
          mosi_d  = (bit_q != 6'd0) ? shreg_q[FRAME_W-2] : 1'b0;
          shreg_d = {shreg_q[FRAME_W-3:0], 1'b0};
        end else if (bit_q != 6'd0) begin
          // rising edge: sample the slave
          sck_d = 1'b1;
          rx_d  = {rx_q[6:0], miso_i};
          bit_d = bit_q - 6'd1;
        end else begin
          // half a period after the last fall: release slave select
          active_d = 1'b0;
          ss_d     = 1'b1;
          done_d   = 1'b1;
          idle_d   = GAP_W'(1);
        end
      end else begin
        div_d = div_q - DIV_W'(1);
      end
    end else begin
      if (idle_q != GAP_MIN) begin
        idle_d = idle_q + GAP_W'(1);
      end else begin
        idle_d = idle_q;
      end
    end
  end

  // Engine state register with synchronous reset to an idle bus.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      active_q <= 1'b0;
      sck_q    <= 1'b0;
      ss_q     <= 1'b1;
      mosi_q   <= 1'b0;
      done_q   <= 1'b0;
      div_q    <= {DIV_W{1'b0}};
      bit_q    <= 6'd0;
      shreg_q  <= {(FRAME_W-1){1'b0}};
      rx_q     <= 8'h00;
      idle_q   <= GAP_MIN;
    end else begin
      active_q <= active_d;
      sck_q    <= sck_d;
      ss_q     <= ss_d;
      mosi_q   <= mosi_d;
      done_q   <= done_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      rx_q     <= rx_d;
      idle_q   <= idle_d;
    end
  end

  assign sck_o     = sck_q;
  assign ss_o      = ss_q;
  assign mosi_o    = mosi_q;
  assign done_o    = done_q;
  assign rx_byte_o = rx_q;
  assign tail_o    = active_q && (bit_q == 6'd0) && !sck_q;
  assign ready_o   = !active_q && (idle_q == GAP_MIN);

endmodule

// File: rtl/spi_flash_master.sv
// Wishbone B3 slave that turns single-byte accesses into SPI flash READ or
// WREN + PAGE PROGRAM command frames.
module spi_flash_master
  import spi_flash_master_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned ADR_WIDTH = 24,
  parameter int unsigned WREN_EN   = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [ADR_WIDTH-1:0] wb_adr_i,
  input  logic [7:0]           wb_dat_i,
  input  logic                 wb_we_i,
  input  logic                 wb_cyc_i,
  input  logic                 wb_stb_i,
  output logic [7:0]           wb_dat_o,
  output logic                 wb_ack_o,
  output logic                 sck_o,
  output logic                 ss_o,
  output logic                 mosi_o,
  input  logic                 miso_i
);

  localparam logic WREN_ON = (WREN_EN != 32'd0);

  state_e                 state_q, state_d;
  logic [ADR_WIDTH-1:0]   adr_q, adr_d;
  logic [7:0]             wdat_q, wdat_d;
  logic                   we_q, we_d;
  logic                   ack_q, ack_d;
  logic [7:0]             rdat_q, rdat_d;

  logic                   start_s;
  logic [5:0]             len_s;
  logic [FRAME_W-1:0]     load_s;
  logic                   ready_s, tail_s, done_s;
  logic [7:0]             rx_s;

  spi_shift_engine #(
    .CLK_DIV (CLK_DIV)
  ) u_engine (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (start_s),
    .len_i     (len_s),
    .load_i    (load_s),
    .miso_i    (miso_i),
    .sck_o     (sck_o),
    .ss_o      (ss_o),
    .mosi_o    (mosi_o),
    .ready_o   (ready_s),
    .tail_o    (tail_s),
    .done_o    (done_s),
    .rx_byte_o (rx_s)
  );

  // Command sequencing and Wishbone handshake; frames always run to completion.
  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    we_d    = we_q;
    ack_d   = 1'b0;
    rdat_d  = rdat_q;
    start_s = 1'b0;
    len_s   = LEN_XFER;
    load_s  = {FRAME_W{1'b0}};
    case (state_q)
      ST_IDLE: begin
        if (wb_cyc_i && wb_stb_i && ready_s) begin
          adr_d   = wb_adr_i;
          wdat_d  = wb_dat_i;
          we_d    = wb_we_i;
          start_s = 1'b1;
          if (wb_we_i && WREN_ON) begin
            len_s   = LEN_CMD;
            load_s  = {OP_WREN, 32'h0000_0000};
            state_d = ST_WREN;
          end else if (wb_we_i) begin
            load_s  = build_frame(OP_PP, wb_adr_i, wb_dat_i);
            state_d = ST_XFER;
          end else begin
            load_s  = build_frame(OP_READ, wb_adr_i, 8'h00);
            state_d = ST_XFER;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WREN: begin
        if (done_s) begin
          state_d = ST_GAP;
        end else begin
          state_d = ST_WREN;
        end
      end
      ST_GAP: begin
        // the engine reports ready once slave select has been high long enough
        if (ready_s) begin
          start_s = 1'b1;
          load_s  = build_frame(OP_PP, adr_q, wdat_q);
          state_d = ST_XFER;
        end else begin
          state_d = ST_GAP;
        end
      end
      ST_XFER: begin
        if (tail_s) begin
          state_d = ST_HOLD;
        end else begin
          state_d = ST_XFER;
        end
      end
      ST_HOLD: begin
        if (done_s) begin
          ack_d   = wb_cyc_i && wb_stb_i;
          state_d = ST_ACK;
          if (!we_q) begin
            rdat_d = rx_s;
          end else begin
            rdat_d = rdat_q;
          end
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Bridge state register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      adr_q   <= {ADR_WIDTH{1'b0}};
      wdat_q  <= 8'h00;
      we_q    <= 1'b0;
      ack_q   <= 1'b0;
      rdat_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      we_q    <= we_d;
      ack_q   <= ack_d;
      rdat_q  <= rdat_d;
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = rdat_q;

endmodule

// File: tb/tb_spi_flash_master.sv
// Self-checking bench: two bridges (WREN on / off) share one emulated flash.
module tb_spi_flash_master;

  localparam int D   = 2;
  localparam int LAT = 163;

  typedef struct {
    logic [39:0] bits;
    int          nbits;
    int          t0;
    int          tend;
    int          tfall;
    int          bad;
    int          gap;
  } frame_t;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic [23:0] adr   = 24'h0;
  logic [7:0]  wdat  = 8'h00;
  logic        we    = 1'b0;
  logic        miso  = 1'b0;
  logic        cyc_a = 1'b0, stb_a = 1'b0, cyc_b = 1'b0, stb_b = 1'b0;
  logic [7:0]  dat_a, dat_b;
  logic        ack_a, ack_b, sck_a, sck_b, ss_a, ss_b, mosi_a, mosi_b;
  logic        sel_b = 1'b0;
  logic        sck_m, ss_m, mosi_m;

  int          cycle   = 0;
  int          n_assert = 0;
  int          n_fail   = 0;
  frame_t      frames[$];
  logic [7:0]  mem [logic [23:0]];

  spi_flash_master #(.CLK_DIV(D), .ADR_WIDTH(24), .WREN_EN(1)) dut_a (
    .clk_i(clk), .rst_i(rst), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_we_i(we),
    .wb_cyc_i(cyc_a), .wb_stb_i(stb_a), .wb_dat_o(dat_a), .wb_ack_o(ack_a),
    .sck_o(sck_a), .ss_o(ss_a), .mosi_o(mosi_a), .miso_i(miso));

  spi_flash_master #(.CLK_DIV(D), .ADR_WIDTH(24), .WREN_EN(0)) dut_b (
    .clk_i(clk), .rst_i(rst), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_we_i(we),
    .wb_cyc_i(cyc_b), .wb_stb_i(stb_b), .wb_dat_o(dat_b), .wb_ack_o(ack_b),
    .sck_o(sck_b), .ss_o(ss_b), .mosi_o(mosi_b), .miso_i(miso));

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  assign sck_m  = sel_b ? sck_b  : sck_a;
  assign ss_m   = sel_b ? ss_b   : ss_a;
  assign mosi_m = sel_b ? mosi_b : mosi_a;

  function automatic logic [7:0] model_read(input logic [23:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5C;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Flash emulation and frame capture, sampled mid-cycle
  logic        prev_ss = 1'b1, prev_sck = 1'b0, rd_on = 1'b0;
  int          t0_m = 0, nb_m = 0, bad_m = 0, gap_m = 0, tfall_m = 0, t_rose = 0;
  logic [39:0] bits_m = 40'h0;
  logic [7:0]  rd_byte = 8'h00;

  always @(negedge clk) begin
    if (prev_ss && !ss_m) begin
      t0_m = cycle; nb_m = 0; bad_m = 0; bits_m = 40'h0; gap_m = cycle - t_rose; rd_on = 1'b0;
    end
    if (!ss_m && !prev_sck && sck_m) begin
      if (cycle != t0_m + D + 2 * D * nb_m) bad_m++;
      bits_m = {bits_m[38:0], mosi_m};
      nb_m++;
      if (nb_m == 32 && bits_m[31:24] == 8'h03) begin
        rd_on = 1'b1;
        rd_byte = model_read(bits_m[23:0]);
      end
    end
    if (!ss_m && prev_sck && !sck_m) tfall_m = cycle;
    if (!prev_ss && ss_m) begin
      frames.push_back('{bits_m, nb_m, t0_m, cycle, tfall_m, bad_m, gap_m});
      t_rose = cycle;
      rd_on = 1'b0;
    end
    if (!ss_m && rd_on && nb_m < 40) miso = rd_byte[7 - (nb_m - 32)];
    else miso = 1'($urandom);
    prev_ss = ss_m;
    prev_sck = sck_m;
  end

  // One Wishbone access; checks frames, timing, ack and read data against the model
  task automatic txn(input bit on_b, input bit w, input logic [23:0] a,
                     input logic [7:0] d, input bit drop);
    int nfr, acks, ack_t, idle;
    logic [7:0] exp_rd, dat_before;
    logic [39:0] exp_bits;
    frame_t f;
    frames.delete();
    sel_b = on_b;
    nfr = (w && !on_b) ? 2 : 1;
    exp_rd = model_read(a);
    exp_bits = w ? {8'h02, a, d} : {8'h03, a, 8'h00};
    dat_before = on_b ? dat_b : dat_a;
    adr = a; wdat = d; we = w;
    if (on_b) begin cyc_b = 1'b1; stb_b = 1'b1; end
    else begin cyc_a = 1'b1; stb_a = 1'b1; end
    acks = 0; ack_t = 0; idle = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (on_b ? ack_b : ack_a) begin
        acks++; ack_t = cycle;
        cyc_a = 1'b0; stb_a = 1'b0; cyc_b = 1'b0; stb_b = 1'b0;
      end
      if (drop && i == 100) begin stb_a = 1'b0; stb_b = 1'b0; end
      if (frames.size() >= nfr) idle++;
      if (idle >= 6) break;
    end
    cyc_a = 1'b0; stb_a = 1'b0; cyc_b = 1'b0; stb_b = 1'b0;
    chk("frame_count", frames.size(), nfr);
    if (frames.size() >= nfr) begin
      f = frames[nfr-1];
      chk("frame_bits", f.bits, exp_bits);
      chk("frame_nbits", f.nbits, 40);
      chk("rise_timing", f.bad, 0);
      chk("last_fall", f.tfall - f.t0, 2 * D * 40);
      chk("ss_rise", f.tend - f.t0, 2 * D * 40 + D);
      chk("ss_gap", f.gap >= 2 * D, 1);
      if (!drop) chk("latency", ack_t - f.t0, LAT);
      if (nfr == 2) begin
        chk("wren_bits", frames[0].bits[7:0], 8'h06);
        chk("wren_nbits", frames[0].nbits, 8);
        chk("wren_end", frames[0].tend - frames[0].t0, 2 * D * 8 + D);
      end
    end
    chk("ack_count", acks, drop ? 0 : 1);
    chk("rd_data", on_b ? dat_b : dat_a, w ? dat_before : exp_rd);
    if (w) mem[a] = d;
  endtask

  // Two reads with cyc and stb held through the first ack
  task automatic b2b(input logic [23:0] a0, input logic [23:0] a1);
    int acks, idle;
    logic [7:0] got0;
    frames.delete();
    sel_b = 1'b0; we = 1'b0; adr = a0; cyc_a = 1'b1; stb_a = 1'b1;
    acks = 0; idle = 0; got0 = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (ack_a) begin
        acks++;
        if (acks == 1) begin got0 = dat_a; adr = a1; end
        else begin cyc_a = 1'b0; stb_a = 1'b0; end
      end
      if (frames.size() >= 2) idle++;
      if (idle >= 6) break;
    end
    cyc_a = 1'b0; stb_a = 1'b0;
    chk("b2b_acks", acks, 2);
    chk("b2b_frames", frames.size(), 2);
    chk("b2b_dat0", got0, model_read(a0));
    chk("b2b_dat1", dat_a, model_read(a1));
    if (frames.size() >= 2) begin
      chk("b2b_gap", frames[1].gap >= 2 * D, 1);
      chk("b2b_bits0", frames[0].bits, {8'h03, a0, 8'h00});
      chk("b2b_bits1", frames[1].bits, {8'h03, a1, 8'h00});
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] ra;
    mem[24'h123456] = 8'hA5;
    repeat (3) @(negedge clk);
    chk("rst_ss", ss_a, 1'b1);
    chk("rst_sck", sck_a, 1'b0);
    chk("rst_mosi", mosi_a, 1'b0);
    chk("rst_ack", ack_a, 1'b0);
    chk("rst_dat", dat_a, 8'h00);
    chk("rst_ss_b", ss_b, 1'b1);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    txn(1'b0, 1'b0, 24'h123456, 8'h00, 1'b0);
    txn(1'b0, 1'b1, 24'h000010, 8'h5A, 1'b0);
    txn(1'b0, 1'b0, 24'h000010, 8'h00, 1'b0);
    txn(1'b1, 1'b1, 24'h000020, 8'hC3, 1'b0);
    txn(1'b1, 1'b0, 24'h000020, 8'h00, 1'b0);
    txn(1'b0, 1'b1, 24'h000030, 8'h77, 1'b1);
    txn(1'b0, 1'b0, 24'h000030, 8'h00, 1'b0);

    // reset in the middle of a read frame
    frames.delete();
    sel_b = 1'b0; we = 1'b0; adr = 24'h0ABCDE; cyc_a = 1'b1; stb_a = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (nb_m >= 20) break;
    end
    chk("reached_bit20", nb_m >= 20, 1'b1);
    rst = 1'b1; cyc_a = 1'b0; stb_a = 1'b0;
    @(negedge clk);
    chk("mid_rst_ss", ss_a, 1'b1);
    chk("mid_rst_sck", sck_a, 1'b0);
    chk("mid_rst_mosi", mosi_a, 1'b0);
    chk("mid_rst_ack", ack_a, 1'b0);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    txn(1'b0, 1'b0, 24'h0ABCDE, 8'h00, 1'b0);

    b2b(24'h000000, 24'h000001);

    for (int n = 0; n < 8; n++) begin
      ra = 24'h000400 + 24'($urandom_range(0, 5));
      txn(1'b0, 1'($urandom_range(0, 1)), ra, 8'($urandom), 1'b0);
    end
    for (int n = 0; n < 3; n++) begin
      ra = 24'h000400 + 24'($urandom_range(0, 5));
      txn(1'b1, 1'($urandom_range(0, 1)), ra, 8'($urandom), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
